uart_receiver: RTL and testbench
================================

Name: uart_receiver

Overview:
- Receive half of the UART controller; counterpart of the existing transmitter.
- Oversamples the serial line using the shared 16x baud tick.
- Deserialises LSB-first frames (5-8 data bits, optional parity, 1-2 stop bits) and checks parity and framing.
- Pushes each received word with its error flags into a first-word-fall-through RX FIFO read by the host interface.
- Detects the peer's configuration request (line held low for an extended time) and raises a one-cycle pulse to the control logic.

Parameters:
RX_FIFO_DEPTH, 64, FIFO entries; any value >= 2, non-power-of-2 allowed.
CONFIG_LOW_CYCLES, 40000, consecutive low clk_i cycles on the synchronised line that signal a configuration request. Must exceed the longest legal all-zero frame (start + 8 data + parity bits) at the slowest supported baud.

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous reset, active-high
enable_i  in  1  permits start-bit detection in IDLE
ov_baud_rt_i  in  1  16x oversampling tick, one clk_i wide
rx_i  in  1  asynchronous serial line, idle high
rx_fifo_read_i  in  1  pop FIFO head; ignored when empty
data_width_i  in  2  00=5, 01=6, 10=7, 11=8 data bits
stop_bits_number_i  in  2  01=2 stop bits, all other codes=1
parity_mode_i  in  2  [1]=1 no parity; [0]=0 even, 1 odd
data_rx_o  out  8  FIFO head data, right-aligned, unused MSBs 0
parity_error_o  out  1  parity-error flag stored with head entry
frame_error_o  out  1  frame-error flag stored with head entry
rx_fifo_empty_o  out  1  FIFO empty
rx_fifo_full_o  out  1  FIFO full
rx_done_o  out  1  1-cycle pulse: frame completed (written or dropped)
overrun_error_o  out  1  1-cycle pulse: completed frame dropped, FIFO full
config_req_slv_o  out  1  1-cycle pulse: configuration request detected
rx_idle_o  out  1  FSM in IDLE

Behaviour:
Reset and line synchronisation
- rx_i passes through a 2-flop synchroniser; both flops reset to 1.
- Reset values: FSM=IDLE, all counters 0, FIFO empty (rx_fifo_empty_o=1, rx_fifo_full_o=0), data_rx_o=0, error flags 0, all pulses 0, rx_idle_o=1.
- Reset mid-frame discards the partial frame.

Frame-reception FSM (states IDLE, START, DATA, PARITY, STOP, CFG_WAIT); sample counter is 4 bits, advances only on ov_baud_rt_i.
- IDLE: synchronised line low and enable_i=1 -> START, counter cleared.
- START: on the tick where counter==7 (mid start bit), line low -> DATA with counter cleared; line high -> false start, back to IDLE.
- DATA: sample on tick with counter==15, then clear counter. Shift in right: sr={line,sr[7:1]}. After N bits (N from data_width_i) -> PARITY if parity_mode_i[1]==0, else STOP. Stored data = sr>>(8-N).
- PARITY: sample at counter==15. parity error = sampled bit != (^data ^ parity_mode_i[0]).
- STOP: sample at counter==15. Any low stop sample sets the frame error. With 2 stop bits, both are sampled; a low first stop bit does not abort the frame.
- On the final stop sample: write {frame_err, parity_err, data} to the FIFO, pulse rx_done_o, return to IDLE. If the FIFO is full and rx_fifo_read_i=0, drop the frame and also pulse overrun_error_o.
- Configuration fields are sampled continuously; they must be stable during a frame.
- enable_i deassert mid-frame: the frame completes normally.

Configuration request detection
- Counter of consecutive low cycles on the synchronised line, saturating at CONFIG_LOW_CYCLES. It clears on any high cycle.
- On reaching CONFIG_LOW_CYCLES: pulse config_req_slv_o once, abort any frame without a write, enter CFG_WAIT.
- CFG_WAIT returns to IDLE only after the line has been high for one ov_baud_rt_i tick.
- Detection takes priority over a same-cycle frame completion.

RX FIFO
- FWFT: head entry is visible on outputs while rx_fifo_empty_o=0. Pop is registered, so the next entry appears the cycle after the read.
- Simultaneous write and read when full: both performed, no overrun, full stays 1.
- Simultaneous write and read when empty: the write is performed and the read is ignored.
- Pointers wrap at RX_FIFO_DEPTH-1.

Test Plan:
- 8N1, 0xA5, 16 ticks/bit -> rx_done_o one pulse; data_rx_o=0xA5, both error flags 0, rx_fifo_empty_o falls.
- 7-bit, odd parity, 2 stop bits, 0x55 with parity bit 1 -> data 0x55, parity_error_o=0. Repeat with parity bit 0 -> parity_error_o=1.
- 5N1, 0x1F, stop bit driven 0 -> data 0x1F, frame_error_o=1. Line then high -> next 0x03 frame received cleanly.
- Low glitch of 4 ticks in IDLE -> no rx_done_o, FIFO stays empty, FSM back in IDLE.
- 65 frames 0x00..0x40 without reads -> 64 stored, 65th gives overrun_error_o pulse. Then 64 reads return 0x00..0x3F in order, and rx_fifo_empty_o=1.
- Line low for CONFIG_LOW_CYCLES cycles -> one config_req_slv_o pulse, no FIFO write. Line high then 8N1 0x3C -> 0x3C received. Reset asserted mid-frame -> FIFO empty, rx_idle_o=1.

Source files
------------

// File: rtl/uart_receiver.sv
// UART receive path: 16x-oversampled deserialiser with parity/framing checks feeding a FWFT RX FIFO.
// Frame result lands in the FIFO on the final stop sample; frames completing while the FIFO is full are dropped.
module uart_receiver #(
   parameter int RX_FIFO_DEPTH     = 64,
   parameter int CONFIG_LOW_CYCLES = 40000
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       enable_i,
   input  logic       ov_baud_rt_i,
   input  logic       rx_i,
   input  logic       rx_fifo_read_i,
   input  logic [1:0] data_width_i,
   input  logic [1:0] stop_bits_number_i,
   input  logic [1:0] parity_mode_i,
   output logic [7:0] data_rx_o,
   output logic       parity_error_o,
   output logic       frame_error_o,
   output logic       rx_fifo_empty_o,
   output logic       rx_fifo_full_o,
   output logic       rx_done_o,
   output logic       overrun_error_o,
   output logic       config_req_slv_o,
   output logic       rx_idle_o
);

   localparam int AW = (RX_FIFO_DEPTH > 1) ? $clog2(RX_FIFO_DEPTH) : 1;
   localparam int CW = $clog2(RX_FIFO_DEPTH + 1);
   localparam int LW = $clog2(CONFIG_LOW_CYCLES + 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, CFG_WAIT} state_t;

   state_t        state, state_n;
   logic          rx_meta, rx_sync;
   logic [LW-1:0] low_cnt;
   logic          cfg_hit;
   logic [3:0]    cnt, cnt_n;
   logic [2:0]    bit_idx, bit_n;
   logic [7:0]    sr, sr_n;
   logic          par_err, par_n;
   logic          frm_err, frm_n;
   logic          stop_idx, stop_n;
   logic          finish;
   logic [3:0]    nbits;
   logic [7:0]    data_aligned;
   logic          two_stop;

   logic [9:0]    mem [RX_FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic          wr_en, rd_en, drop;
   logic [9:0]    head;

   assign nbits        = 4'd5 + {2'b00, data_width_i};
   assign data_aligned = sr >> (4'd8 - nbits);
   assign two_stop     = (stop_bits_number_i == 2'b01);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         rx_meta <= rx_i;
         rx_sync <= rx_meta;
      end
   end

   // Saturating low-time counter; cfg_hit marks the cycle it reaches the limit.
   always_ff @(posedge clk_i) begin
      if (rst_i || rx_sync)
         low_cnt <= '0;
      else if (low_cnt != LW'(CONFIG_LOW_CYCLES))
         low_cnt <= low_cnt + 1'b1;
   end

   assign cfg_hit = !rx_sync && (low_cnt == LW'(CONFIG_LOW_CYCLES - 1));

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      bit_n   = bit_idx;
      sr_n    = sr;
      par_n   = par_err;
      frm_n   = frm_err;
      stop_n  = stop_idx;
      finish  = 1'b0;
      case (state)
         IDLE: begin
            if (!rx_sync && enable_i) begin
               state_n = START;
               cnt_n   = '0;
            end
         end
         START: begin
            if (ov_baud_rt_i) begin
               if (cnt == 4'd7) begin
                  cnt_n = '0;
                  if (!rx_sync) begin
                     state_n = DATA;
                     bit_n   = '0;
                     par_n   = 1'b0;
                     frm_n   = 1'b0;
                  end else begin
                     state_n = IDLE;
                  end
               end else begin
                  cnt_n = cnt + 4'd1;
               end
            end
         end
         DATA: begin
            if (ov_baud_rt_i) begin
               if (cnt == 4'd15) begin
                  cnt_n = '0;
                  sr_n  = {rx_sync, sr[7:1]};
                  if ({1'b0, bit_idx} == nbits - 4'd1) begin
                     state_n = parity_mode_i[1] ? STOP : PARITY;
                     stop_n  = 1'b0;
                  end else begin
                     bit_n = bit_idx + 3'd1;
                  end
               end else begin
                  cnt_n = cnt + 4'd1;
               end
            end
         end
         PARITY: begin
            if (ov_baud_rt_i) begin
               if (cnt == 4'd15) begin
                  cnt_n   = '0;
                  par_n   = rx_sync != (^data_aligned ^ parity_mode_i[0]);
                  state_n = STOP;
                  stop_n  = 1'b0;
               end else begin
                  cnt_n = cnt + 4'd1;
               end
            end
         end
         STOP: begin
            if (ov_baud_rt_i) begin
               if (cnt == 4'd15) begin
                  cnt_n = '0;
                  if (!rx_sync)
                     frm_n = 1'b1;
                  if (two_stop && !stop_idx) begin
                     stop_n = 1'b1;
                  end else begin
                     finish  = 1'b1;
                     state_n = IDLE;
                  end
               end else begin
                  cnt_n = cnt + 4'd1;
               end
            end
         end
         CFG_WAIT: begin
            if (ov_baud_rt_i && rx_sync)
               state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
      // A configuration request wins over anything the frame logic wanted this cycle.
      if (cfg_hit) begin
         state_n = CFG_WAIT;
         cnt_n   = '0;
         finish  = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state            <= IDLE;
         cnt              <= '0;
         bit_idx          <= '0;
         sr               <= '0;
         par_err          <= 1'b0;
         frm_err          <= 1'b0;
         stop_idx         <= 1'b0;
         rx_done_o        <= 1'b0;
         overrun_error_o  <= 1'b0;
         config_req_slv_o <= 1'b0;
      end else begin
         state            <= state_n;
         cnt              <= cnt_n;
         bit_idx          <= bit_n;
         sr               <= sr_n;
         par_err          <= par_n;
         frm_err          <= frm_n;
         stop_idx         <= stop_n;
         rx_done_o        <= finish;
         overrun_error_o  <= drop;
         config_req_slv_o <= cfg_hit;
      end
   end

   assign rx_idle_o = (state == IDLE);

   // A pop in the same cycle frees the slot, so a full FIFO still accepts the write.
   assign wr_en = finish && (!rx_fifo_full_o || rx_fifo_read_i);
   assign drop  = finish && !wr_en;
   assign rd_en = rx_fifo_read_i && !rx_fifo_empty_o;

   always_ff @(posedge clk_i) begin
      if (wr_en)
         mem[wr_ptr] <= {frm_n, par_err, data_aligned};
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en)
            wr_ptr <= (wr_ptr == AW'(RX_FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
         if (rd_en)
            rd_ptr <= (rd_ptr == AW'(RX_FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
         case ({wr_en, rd_en})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign rx_fifo_empty_o = (count == '0);
   assign rx_fifo_full_o  = (count == CW'(RX_FIFO_DEPTH));
   assign head            = rx_fifo_empty_o ? 10'd0 : mem[rd_ptr];
   assign data_rx_o       = head[7:0];
   assign parity_error_o  = head[8];
   assign frame_error_o   = head[9];

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: frames formats, errors, glitch, overrun, config request, reset.
module tb_uart_receiver;

   localparam int CFG_LOW = 1000;
   localparam int BIT_CLK = 32;   // tick every 2 clk, 16 ticks per bit

   logic       clk = 1'b0;
   logic       rst_i = 1'b1;
   logic       enable_i = 1'b0;
   logic       ov_baud_rt_i = 1'b0;
   logic       rx_i = 1'b1;
   logic       rx_fifo_read_i = 1'b0;
   logic [1:0] data_width_i = 2'b11;
   logic [1:0] stop_bits_number_i = 2'b00;
   logic [1:0] parity_mode_i = 2'b10;
   logic [7:0] data_rx_o;
   logic       parity_error_o, frame_error_o, rx_fifo_empty_o, rx_fifo_full_o;
   logic       rx_done_o, overrun_error_o, config_req_slv_o, rx_idle_o;

   int total = 0;
   int bad = 0;
   int n_done = 0;
   int n_ovr = 0;
   int n_cfg = 0;
   int tick_div = 0;

   uart_receiver #(.RX_FIFO_DEPTH(64), .CONFIG_LOW_CYCLES(CFG_LOW)) dut (
      .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i), .ov_baud_rt_i(ov_baud_rt_i),
      .rx_i(rx_i), .rx_fifo_read_i(rx_fifo_read_i), .data_width_i(data_width_i),
      .stop_bits_number_i(stop_bits_number_i), .parity_mode_i(parity_mode_i),
      .data_rx_o(data_rx_o), .parity_error_o(parity_error_o), .frame_error_o(frame_error_o),
      .rx_fifo_empty_o(rx_fifo_empty_o), .rx_fifo_full_o(rx_fifo_full_o), .rx_done_o(rx_done_o),
      .overrun_error_o(overrun_error_o), .config_req_slv_o(config_req_slv_o), .rx_idle_o(rx_idle_o)
   );

   always #5 clk = ~clk;

   initial begin
      forever begin
         @(negedge clk);
         tick_div = tick_div + 1;
         ov_baud_rt_i = (tick_div % 2 == 0);
      end
   end

   always @(negedge clk) begin
      if (rx_done_o)        n_done = n_done + 1;
      if (overrun_error_o)  n_ovr  = n_ovr + 1;
      if (config_req_slv_o) n_cfg  = n_cfg + 1;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_cfg(input logic [1:0] w, input logic [1:0] s, input logic [1:0] p);
      data_width_i = w;
      stop_bits_number_i = s;
      parity_mode_i = p;
   endtask

   task automatic send_frame(input logic [7:0] d, input int nbits, input bit par_en,
                             input logic par_bit, input int nstop, input logic stop_val);
      logic [7:0] dv;
      dv = d;
      @(negedge clk);
      rx_i = 1'b0;
      wait_clk(BIT_CLK);
      for (int i = 0; i < nbits; i++) begin
         rx_i = dv[i];
         wait_clk(BIT_CLK);
      end
      if (par_en) begin
         rx_i = par_bit;
         wait_clk(BIT_CLK);
      end
      for (int s = 0; s < nstop; s++) begin
         rx_i = stop_val;
         // last stop bit is cut short so a low stop cannot look like a start bit
         wait_clk((s == nstop - 1) ? 20 : BIT_CLK);
      end
      rx_i = 1'b1;
      wait_clk(48);
   endtask

   task automatic pop;
      @(negedge clk);
      rx_fifo_read_i = 1'b1;
      @(negedge clk);
      rx_fifo_read_i = 1'b0;
   endtask

   task automatic test_reset;
      rst_i = 1'b1;
      wait_clk(4);
      rst_i = 1'b0;
      @(negedge clk);
      total++; if (rx_fifo_empty_o !== 1'b1) begin bad++; $display("FAIL reset_empty: got %b want 1", rx_fifo_empty_o); end
      total++; if (rx_fifo_full_o !== 1'b0) begin bad++; $display("FAIL reset_full: got %b want 0", rx_fifo_full_o); end
      total++; if (data_rx_o !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", data_rx_o); end
      total++; if ({parity_error_o, frame_error_o} !== 2'b00) begin bad++; $display("FAIL reset_flags: got %b want 00", {parity_error_o, frame_error_o}); end
      total++; if (rx_idle_o !== 1'b1) begin bad++; $display("FAIL reset_idle: got %b want 1", rx_idle_o); end
      total++; if ({rx_done_o, overrun_error_o, config_req_slv_o} !== 3'b000) begin bad++; $display("FAIL reset_pulses: got %b want 000", {rx_done_o, overrun_error_o, config_req_slv_o}); end
   endtask

   task automatic test_8n1;
      int d0;
      enable_i = 1'b1;
      set_cfg(2'b11, 2'b00, 2'b10);
      d0 = n_done;
      send_frame(8'hA5, 8, 0, 1'b0, 1, 1'b1);
      total++; if (n_done - d0 !== 1) begin bad++; $display("FAIL 8n1_done: got %0d pulses want 1", n_done - d0); end
      total++; if (data_rx_o !== 8'hA5) begin bad++; $display("FAIL 8n1_data: got %h want a5", data_rx_o); end
      total++; if ({parity_error_o, frame_error_o} !== 2'b00) begin bad++; $display("FAIL 8n1_flags: got %b want 00", {parity_error_o, frame_error_o}); end
      total++; if (rx_fifo_empty_o !== 1'b0) begin bad++; $display("FAIL 8n1_empty: got %b want 0", rx_fifo_empty_o); end
      pop();
      total++; if (rx_fifo_empty_o !== 1'b1) begin bad++; $display("FAIL 8n1_pop_empty: got %b want 1", rx_fifo_empty_o); end
   endtask

   task automatic test_parity;
      set_cfg(2'b10, 2'b01, 2'b01);
      send_frame(8'h55, 7, 1, 1'b1, 2, 1'b1);
      total++; if (data_rx_o !== 8'h55) begin bad++; $display("FAIL par_ok_data: got %h want 55", data_rx_o); end
      total++; if ({parity_error_o, frame_error_o} !== 2'b00) begin bad++; $display("FAIL par_ok_flags: got %b want 00", {parity_error_o, frame_error_o}); end
      pop();
      send_frame(8'h55, 7, 1, 1'b0, 2, 1'b1);
      total++; if (data_rx_o !== 8'h55) begin bad++; $display("FAIL par_bad_data: got %h want 55", data_rx_o); end
      total++; if ({parity_error_o, frame_error_o} !== 2'b10) begin bad++; $display("FAIL par_bad_flags: got %b want 10", {parity_error_o, frame_error_o}); end
      pop();
   endtask

   task automatic test_frame_error;
      set_cfg(2'b00, 2'b00, 2'b10);
      send_frame(8'h1F, 5, 0, 1'b0, 1, 1'b0);
      total++; if (data_rx_o !== 8'h1F) begin bad++; $display("FAIL ferr_data: got %h want 1f", data_rx_o); end
      total++; if ({parity_error_o, frame_error_o} !== 2'b01) begin bad++; $display("FAIL ferr_flags: got %b want 01", {parity_error_o, frame_error_o}); end
      pop();
      total++; if (rx_fifo_empty_o !== 1'b1) begin bad++; $display("FAIL ferr_no_false_start: got empty=%b want 1", rx_fifo_empty_o); end
      send_frame(8'h03, 5, 0, 1'b0, 1, 1'b1);
      total++; if (data_rx_o !== 8'h03) begin bad++; $display("FAIL ferr_next_data: got %h want 03", data_rx_o); end
      total++; if ({parity_error_o, frame_error_o} !== 2'b00) begin bad++; $display("FAIL ferr_next_flags: got %b want 00", {parity_error_o, frame_error_o}); end
      pop();
   endtask

   task automatic test_glitch;
      int d0;
      set_cfg(2'b11, 2'b00, 2'b10);
      d0 = n_done;
      @(negedge clk);
      rx_i = 1'b0;
      wait_clk(8);
      rx_i = 1'b1;
      wait_clk(80);
      total++; if (n_done !== d0) begin bad++; $display("FAIL glitch_done: got %0d pulses want 0", n_done - d0); end
      total++; if (rx_fifo_empty_o !== 1'b1) begin bad++; $display("FAIL glitch_empty: got %b want 1", rx_fifo_empty_o); end
      total++; if (rx_idle_o !== 1'b1) begin bad++; $display("FAIL glitch_idle: got %b want 1", rx_idle_o); end
   endtask

   task automatic test_overrun;
      int d0, o0;
      set_cfg(2'b11, 2'b00, 2'b10);
      d0 = n_done;
      o0 = n_ovr;
      for (int i = 0; i < 64; i++) send_frame(8'(i), 8, 0, 1'b0, 1, 1'b1);
      total++; if (rx_fifo_full_o !== 1'b1) begin bad++; $display("FAIL ovr_full64: got %b want 1", rx_fifo_full_o); end
      total++; if (n_ovr !== o0) begin bad++; $display("FAIL ovr_early: got %0d overruns want 0", n_ovr - o0); end
      send_frame(8'h40, 8, 0, 1'b0, 1, 1'b1);
      total++; if (n_ovr - o0 !== 1) begin bad++; $display("FAIL ovr_pulse: got %0d want 1", n_ovr - o0); end
      total++; if (n_done - d0 !== 65) begin bad++; $display("FAIL ovr_done: got %0d want 65", n_done - d0); end
      for (int i = 0; i < 64; i++) begin
         total++; if (data_rx_o !== 8'(i)) begin bad++; $display("FAIL ovr_read%0d: got %h want %h", i, data_rx_o, 8'(i)); end
         pop();
      end
      total++; if (rx_fifo_empty_o !== 1'b1) begin bad++; $display("FAIL ovr_drain_empty: got %b want 1", rx_fifo_empty_o); end
      total++; if (rx_fifo_full_o !== 1'b0) begin bad++; $display("FAIL ovr_drain_full: got %b want 0", rx_fifo_full_o); end
   endtask

   task automatic test_config;
      int c0, d0;
      c0 = n_cfg;
      d0 = n_done;
      enable_i = 1'b0;
      @(negedge clk);
      rx_i = 1'b0;
      for (int k = 0; k < CFG_LOW + 100 && n_cfg == c0; k++) @(negedge clk);
      wait_clk(200);
      total++; if (n_cfg - c0 !== 1) begin bad++; $display("FAIL cfg_pulse: got %0d want 1", n_cfg - c0); end
      total++; if (n_done !== d0) begin bad++; $display("FAIL cfg_done: got %0d want 0", n_done - d0); end
      total++; if (rx_fifo_empty_o !== 1'b1) begin bad++; $display("FAIL cfg_empty: got %b want 1", rx_fifo_empty_o); end
      total++; if (rx_idle_o !== 1'b0) begin bad++; $display("FAIL cfg_wait_state: got idle=%b want 0", rx_idle_o); end
      rx_i = 1'b1;
      wait_clk(8);
      total++; if (rx_idle_o !== 1'b1) begin bad++; $display("FAIL cfg_back_idle: got %b want 1", rx_idle_o); end
      enable_i = 1'b1;
      set_cfg(2'b11, 2'b00, 2'b10);
      send_frame(8'h3C, 8, 0, 1'b0, 1, 1'b1);
      total++; if (data_rx_o !== 8'h3C) begin bad++; $display("FAIL cfg_next_data: got %h want 3c", data_rx_o); end
      total++; if (n_done - d0 !== 1) begin bad++; $display("FAIL cfg_next_done: got %0d want 1", n_done - d0); end
   endtask

   task automatic test_reset_midframe;
      int d0;
      d0 = n_done;
      total++; if (rx_fifo_empty_o !== 1'b0) begin bad++; $display("FAIL rstmid_pre_empty: got %b want 0", rx_fifo_empty_o); end
      @(negedge clk);
      rx_i = 1'b0;
      wait_clk(BIT_CLK);
      rx_i = 1'b1;
      wait_clk(BIT_CLK);
      rx_i = 1'b0;
      wait_clk(BIT_CLK / 2);
      total++; if (rx_idle_o !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got idle=%b want 0", rx_idle_o); end
      rst_i = 1'b1;
      wait_clk(2);
      rst_i = 1'b0;
      rx_i = 1'b1;
      wait_clk(3 * BIT_CLK);
      total++; if (rx_fifo_empty_o !== 1'b1) begin bad++; $display("FAIL rstmid_empty: got %b want 1", rx_fifo_empty_o); end
      total++; if (rx_idle_o !== 1'b1) begin bad++; $display("FAIL rstmid_idle: got %b want 1", rx_idle_o); end
      total++; if (n_done !== d0) begin bad++; $display("FAIL rstmid_done: got %0d want 0", n_done - d0); end
      total++; if (data_rx_o !== 8'h00) begin bad++; $display("FAIL rstmid_data: got %h want 00", data_rx_o); end
   endtask

   initial begin
      test_reset();
      test_8n1();
      test_parity();
      test_frame_error();
      test_glitch();
      test_overrun();
      test_config();
      test_reset_midframe();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
